// File: rtl/multi_channel_result_writer.sv
// Purpose : Arbitrates DSM status writes and NUM_CH result streams onto one SPL write-request port.
// Latency : one cycle from grant to wr_valid; a channel push is visible to the arbiter the next cycle.
// Backpressure: wr_almostfull blocks new grants; per-channel ch_ready drops when its FIFO is full.
//
// Ports:
//   clk, resetb        clock, asynchronous active-low reset
//   dsm_base_valid/dsm_base, status_req/status_data/status_ack   DSM status write path
//   flush              synchronous clear of offsets and FIFOs
//   ch_valid/ch_data/ch_ready   per-channel result push (valid/ready)
//   ch_base/ch_lines   per-channel buffer base (cache line) and length (0 = disabled)
//   ch_done            pulse with the write that wraps a channel's offset
//   wr_almostfull, wr_valid/wr_phys/wr_addr/wr_data   SPL write request
//   tx_count           total writes issued; overflow   sticky per-channel drop flag

// Purpose : generic synchronous FIFO with clear; head word is presented combinationally.
// Latency : a push is readable on the following cycle.
// Backpressure: o_full; a push while full is accepted only together with a pop.
module mcrw_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr) r_mem[r_wptr[AW-1:0]] <= i_dat;
    end

    assign o_dat   = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

module multi_channel_result_writer #(
    parameter int DATA_W     = 512,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_W     = 58,
    parameter int OFF_W      = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     dsm_base_valid,
    input  logic [ADDR_W-1:0]        dsm_base,
    input  logic                     status_req,
    input  logic [DATA_W-1:0]        status_data,
    output logic                     status_ack,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*ADDR_W-1:0] ch_base,
    input  logic [NUM_CH*OFF_W-1:0]  ch_lines,
    output logic [NUM_CH-1:0]        ch_done,
    input  logic                     wr_almostfull,
    output logic                     wr_valid,
    output logic                     wr_phys,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [31:0]              tx_count,
    output logic [NUM_CH-1:0]        overflow
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W:0] NUM_CH_L = (PTR_W+1)'(NUM_CH);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

    state_t              r_state;
    logic                r_alive;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [OFF_W-1:0]    r_off [NUM_CH];
    logic                r_wr_valid;
    logic                r_wr_phys;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_status_ack;
    logic [NUM_CH-1:0]   r_ch_done;
    logic [31:0]         r_tx_count;
    logic [NUM_CH-1:0]   r_overflow;

    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_empty;
    logic [NUM_CH-1:0]   w_push;
    logic [NUM_CH-1:0]   w_pop;
    logic [NUM_CH-1:0]   w_elig;
    logic [DATA_W-1:0]   w_head  [NUM_CH];
    logic [ADDR_W-1:0]   w_base  [NUM_CH];
    logic [OFF_W-1:0]    w_lines [NUM_CH];

    logic                w_found;
    logic [PTR_W-1:0]    w_grant_ch;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_next_ptr;
    logic                w_issue_ok;
    logic                w_init_go;
    logic                w_status_go;
    logic                w_chan_go;
    logic                w_gr_last;
    logic [ADDR_W-1:0]   w_ch_addr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_base[g]  = ch_base[g*ADDR_W +: ADDR_W];
        assign w_lines[g] = ch_lines[g*OFF_W +: OFF_W];
        // r_alive holds ch_ready low while in reset and for the first cycle after.
        assign ch_ready[g] = r_alive && !w_full[g];
        // flush outranks a push in the same cycle.
        assign w_push[g]   = ch_valid[g] && ch_ready[g] && !flush;
        assign w_elig[g]   = !w_empty[g] && (w_lines[g] != '0);
        assign w_pop[g]    = w_chan_go && (w_grant_ch == PTR_W'(g));

        mcrw_fifo #(
            .W     (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst_n (resetb),
            .i_clr   (flush),
            .i_push  (w_push[g]),
            .i_dat   (ch_data[g*DATA_W +: DATA_W]),
            .i_pop   (w_pop[g]),
            .o_dat   (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Round-robin search: first eligible channel at or after the pointer.
    always_comb begin
        w_found    = 1'b0;
        w_grant_ch = '0;
        w_sum      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= NUM_CH_L) w_sum = w_sum - NUM_CH_L;
            if (!w_found && w_elig[w_sum[PTR_W-1:0]]) begin
                w_found    = 1'b1;
                w_grant_ch = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_next_ptr  = (w_grant_ch == PTR_W'(NUM_CH-1)) ? '0 : w_grant_ch + PTR_W'(1);
    assign w_issue_ok  = (r_state == ST_RUN) && !wr_almostfull && !flush;
    assign w_init_go   = (r_state == ST_INIT) && dsm_base_valid && !wr_almostfull && !flush;
    assign w_status_go = w_issue_ok && status_req;
    assign w_chan_go   = w_issue_ok && !status_req && w_found;
    assign w_ch_addr   = w_base[w_grant_ch] + ADDR_W'(r_off[w_grant_ch]);
    // >= rather than == so a buffer shrunk below the current offset still wraps.
    assign w_gr_last   = (r_off[w_grant_ch] >= (w_lines[w_grant_ch] - OFF_W'(1)));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= ST_INIT;
            r_alive      <= 1'b0;
            r_rr_ptr     <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_phys    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_status_ack <= 1'b0;
            r_ch_done    <= '0;
            r_tx_count   <= '0;
            r_overflow   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_off[i] <= '0;
        end else begin
            r_alive      <= 1'b1;
            r_wr_valid   <= 1'b0;
            r_wr_phys    <= 1'b0;
            r_status_ack <= 1'b0;
            r_ch_done    <= '0;
            r_overflow   <= r_overflow | (ch_valid & ~ch_ready);

            if (w_init_go || w_status_go) begin
                r_wr_valid   <= 1'b1;
                r_wr_phys    <= 1'b1;
                r_wr_addr    <= dsm_base;
                r_wr_data    <= status_data;
                r_status_ack <= 1'b1;
                r_tx_count   <= r_tx_count + 32'd1;
            end else if (w_chan_go) begin
                r_wr_valid   <= 1'b1;
                r_wr_phys    <= 1'b0;
                r_wr_addr    <= w_ch_addr;
                r_wr_data    <= w_head[w_grant_ch];
                r_tx_count   <= r_tx_count + 32'd1;
                r_rr_ptr     <= w_next_ptr;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_grant_ch == PTR_W'(i)) r_ch_done[i] <= w_gr_last;
                end
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (flush) begin
                    r_off[i] <= '0;
                end else if (w_chan_go && (w_grant_ch == PTR_W'(i))) begin
                    r_off[i] <= w_gr_last ? '0 : r_off[i] + OFF_W'(1);
                end
            end

            if (flush) begin
                r_state <= ST_FLUSH;
            end else begin
                case (r_state)
                    ST_INIT:  if (w_init_go) r_state <= ST_RUN;
                    ST_RUN:   r_state <= ST_RUN;
                    ST_FLUSH: r_state <= dsm_base_valid ? ST_RUN : ST_INIT;
                    default:  r_state <= ST_INIT;
                endcase
            end
        end
    end

    assign wr_valid   = r_wr_valid;
    assign wr_phys    = r_wr_phys;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign status_ack = r_status_ack;
    assign ch_done    = r_ch_done;
    assign tx_count   = r_tx_count;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_multi_channel_result_writer.sv
// Purpose : directed bench for multi_channel_result_writer with a write scoreboard.
// Latency : expected writes queued at stimulus time, popped by a negedge monitor.
// Backpressure: drives wr_almostfull directly to exercise stall, full and overflow.
module tb_multi_channel_result_writer;
    localparam int DATA_W     = 512;
    localparam int NUM_CH     = 2;
    localparam int FIFO_DEPTH = 32;
    localparam int ADDR_W     = 58;
    localparam int OFF_W      = 16;

    logic                     clk = 1'b0;
    logic                     resetb;
    logic                     dsm_base_valid;
    logic [ADDR_W-1:0]        dsm_base;
    logic                     status_req;
    logic [DATA_W-1:0]        status_data;
    logic                     status_ack;
    logic                     flush;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*ADDR_W-1:0] ch_base;
    logic [NUM_CH*OFF_W-1:0]  ch_lines;
    logic [NUM_CH-1:0]        ch_done;
    logic                     wr_almostfull;
    logic                     wr_valid;
    logic                     wr_phys;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [31:0]              tx_count;
    logic [NUM_CH-1:0]        overflow;

    typedef struct {
        logic              phys;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic [NUM_CH-1:0] done;
        logic              ack;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;

    multi_channel_result_writer #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W(ADDR_W), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .resetb(resetb),
        .dsm_base_valid(dsm_base_valid), .dsm_base(dsm_base),
        .status_req(status_req), .status_data(status_data), .status_ack(status_ack),
        .flush(flush),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .ch_base(ch_base), .ch_lines(ch_lines), .ch_done(ch_done),
        .wr_almostfull(wr_almostfull),
        .wr_valid(wr_valid), .wr_phys(wr_phys), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_count(tx_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk(input int ch, input int n);
        logic [DATA_W-1:0] d;
        d = '0;
        d[31:0]       = 32'hA000_0000 | (32'(ch) << 16) | 32'(n);
        d[287:256]    = 32'(n * 7 + ch);
        d[DATA_W-1 -: 32] = ~d[31:0];
        return d;
    endfunction

    task automatic expect_wr(input logic phys, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] dat, input logic [NUM_CH-1:0] done,
                             input logic ack);
        exp_t e;
        e.phys = phys; e.addr = addr; e.dat = dat; e.done = done; e.ack = ack;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push n consecutive lines (indices first..first+n-1) on one channel.
    task automatic push_ch(input int ch, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            ch_valid = '0;
            ch_valid[ch] = 1'b1;
            ch_data[ch*DATA_W +: DATA_W] = mk(ch, first + k);
            tick();
        end
        ch_valid = '0;
    endtask

    task automatic push_both(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            ch_valid = '1;
            ch_data[0 +: DATA_W]      = mk(0, first + k);
            ch_data[DATA_W +: DATA_W] = mk(1, first + k);
            tick();
        end
        ch_valid = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && q.size() > 0; i++) tick();
        check({name, "_drain_left"}, 64'(q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every presented write must match the oldest expectation.
    always @(negedge clk) begin
        if (resetb === 1'b1) begin
            if (wr_valid === 1'b1) begin
                wr_seen++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write #%0d: addr %0h phys %0b", wr_seen, wr_addr, wr_phys);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    if (wr_phys !== e.phys || wr_addr !== e.addr || wr_data !== e.dat ||
                        ch_done !== e.done || status_ack !== e.ack) begin
                        errors++;
                        $display("FAIL write#%0d: got phys %0b addr %0h dat %0h done %b ack %b, expected phys %0b addr %0h dat %0h done %b ack %b",
                                 wr_seen, wr_phys, wr_addr, wr_data[31:0], ch_done, status_ack,
                                 e.phys, e.addr, e.dat[31:0], e.done, e.ack);
                    end
                end
            end else if (status_ack !== 1'b0 || ch_done !== '0) begin
                errors++;
                $display("FAIL stray_pulse: ack %b done %b without wr_valid", status_ack, ch_done);
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    localparam logic [DATA_W-1:0] S0 = {16{32'h5A5A_0000}};
    localparam logic [DATA_W-1:0] S1 = {16{32'h5A5A_0001}};
    localparam logic [DATA_W-1:0] S2 = {16{32'h5A5A_0002}};

    initial begin
        resetb = 1'b0; dsm_base_valid = 1'b0; dsm_base = '0; status_req = 1'b0;
        status_data = '0; flush = 1'b0; ch_valid = '0; ch_data = '0;
        ch_base = '0; ch_lines = '0; wr_almostfull = 1'b0;
        tick(); tick();

        // Reset state: all outputs low.
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_status_ack", 64'(status_ack), 64'd0);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        check("rst_ch_ready", 64'(ch_ready), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);

        // INIT status write.
        dsm_base = 58'h100; status_data = S0; dsm_base_valid = 1'b1;
        expect_wr(1'b1, 58'h100, S0, 2'b00, 1'b1);
        resetb = 1'b1;
        drain("init");
        for (int i = 0; i < 4; i++) tick();
        check("init_tx_count", 64'(tx_count), 64'd1);
        check("init_ch_ready", 64'(ch_ready), 64'd3);

        // Two channels, 4 lines each, alternating with done on the wrap.
        ch_base  = {58'h2000, 58'h1000};
        ch_lines = {16'd4, 16'd4};
        for (int n = 0; n < 4; n++) begin
            expect_wr(1'b0, 58'h1000 + 58'(n), mk(0, n), (n == 3) ? 2'b01 : 2'b00, 1'b0);
            expect_wr(1'b0, 58'h2000 + 58'(n), mk(1, n), (n == 3) ? 2'b10 : 2'b00, 1'b0);
        end
        push_both(0, 4);
        drain("rr");
        check("rr_tx_count", 64'(tx_count), 64'd9);

        // Status priority; pointer left at ch1 by a single ch0 write.
        expect_wr(1'b0, 58'h1000, mk(0, 10), 2'b00, 1'b0);
        push_ch(0, 10, 1);
        drain("pre_status");
        wr_almostfull = 1'b1;
        push_both(11, 2);
        tick();
        expect_wr(1'b1, 58'h100, S1, 2'b00, 1'b1);
        expect_wr(1'b0, 58'h2000, mk(1, 11), 2'b00, 1'b0);
        expect_wr(1'b0, 58'h1001, mk(0, 11), 2'b00, 1'b0);
        expect_wr(1'b0, 58'h2001, mk(1, 12), 2'b00, 1'b0);
        expect_wr(1'b0, 58'h1002, mk(0, 12), 2'b00, 1'b0);
        status_data = S1; status_req = 1'b1; wr_almostfull = 1'b0;
        tick();
        status_req = 1'b0;
        drain("status");
        check("status_tx_count", 64'(tx_count), 64'd15);

        // Fill ch0 under back-pressure, overflow on line 33, then release.
        wr_almostfull = 1'b1;
        push_ch(0, 100, FIFO_DEPTH + 1);
        check("full_ch_ready", 64'(ch_ready), 64'd2);
        check("full_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("stall_no_write", 64'(wr_seen), 64'd15);
        for (int n = 0; n < FIFO_DEPTH; n++)
            expect_wr(1'b0, 58'h1000 + 58'((3 + n) % 4), mk(0, 100 + n),
                      ((n % 4) == 0) ? 2'b01 : 2'b00, 1'b0);
        wr_almostfull = 1'b0;
        tick();
        check("resume_wr_valid", 64'(wr_valid), 64'd1);
        drain("full");
        check("sticky_overflow", 64'(overflow), 64'd1);
        check("full_tx_count", 64'(tx_count), 64'd47);
        check("empty_ch_ready", 64'(ch_ready), 64'd3);

        // Flush mid-buffer: queued lines discarded, offset back to base.
        expect_wr(1'b0, 58'h1003, mk(0, 200), 2'b01, 1'b0);
        expect_wr(1'b0, 58'h1000, mk(0, 201), 2'b00, 1'b0);
        push_ch(0, 200, 2);
        drain("preflush");
        wr_almostfull = 1'b1;
        push_ch(0, 202, 2);
        flush = 1'b1; wr_almostfull = 1'b0;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("flush_no_write", 64'(tx_count), 64'd49);
        expect_wr(1'b0, 58'h1000, mk(0, 204), 2'b00, 1'b0);
        push_ch(0, 204, 1);
        drain("postflush");
        check("flush_tx_count", 64'(tx_count), 64'd50);

        // Reset mid-operation with lines queued on ch1.
        wr_almostfull = 1'b1;
        push_ch(1, 300, 2);
        resetb = 1'b0;
        #1;
        check("midrst_wr_valid", 64'(wr_valid), 64'd0);
        check("midrst_tx_count", 64'(tx_count), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_ch_ready", 64'(ch_ready), 64'd0);
        status_data = S2; wr_almostfull = 1'b0;
        tick();
        expect_wr(1'b1, 58'h100, S2, 2'b00, 1'b1);
        resetb = 1'b1;
        drain("rerun");
        for (int i = 0; i < 6; i++) tick();
        check("rerun_tx_count", 64'(tx_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_channel_result_writer.md
Name: multi_channel_result_writer

Overview:
- Parametrised successor to the single-stream DSM/result writer. It arbitrates NUM_CH independent result streams plus DSM status updates onto the single SPL/CCI write-request channel.
- Each channel has its own FIFO, its own virtual buffer base, and a wrapping line offset.
- DSM status writes always take priority. Result channels are served round-robin.
- Sits between the AFU compute writers and the SPL write port.

Parameters:
- DATA_W, 512, data bits per cache-line write.
- NUM_CH, 2, number of result channels (1..8).
- FIFO_DEPTH, 32, entries per channel FIFO (power of two, at least 4).
- ADDR_W, 58, width of a cache-line address.
- OFF_W, 16, width of the per-channel line offset.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- dsm_base_valid  in  1  DSM base programmed by software
- dsm_base  in  ADDR_W  DSM cache-line address (physical)
- status_req  in  1  level; a status write is requested
- status_data  in  DATA_W  status line contents
- status_ack  out  1  one-cycle pulse when a status write issues
- flush  in  1  synchronous clear of all offsets and FIFOs
- ch_valid  in  NUM_CH  per-channel result valid
- ch_data  in  NUM_CH*DATA_W  per-channel result data
- ch_ready  out  NUM_CH  per-channel not-full
- ch_base  in  NUM_CH*ADDR_W  per-channel virtual buffer base (cache-line)
- ch_lines  in  NUM_CH*OFF_W  per-channel buffer length in lines (0 = channel disabled)
- ch_done  out  NUM_CH  one-cycle pulse when a channel's last line issues
- wr_almostfull  in  1  SPL write channel back-pressure
- wr_valid  out  1  write request valid
- wr_phys  out  1  1 = physical address, 0 = virtual
- wr_addr  out  ADDR_W  cache-line address
- wr_data  out  DATA_W  line data
- tx_count  out  32  total writes issued
- overflow  out  NUM_CH  sticky; ch_valid was asserted while ch_ready was 0

Behaviour:
- Reset values: every output is 0. FSM enters INIT. Offsets, FIFOs and the round-robin pointer are cleared; the pointer starts at channel 0.
- Channel FIFO accept:
  - ch_ready[i] = FIFO not full.
  - Push when ch_valid[i] and ch_ready[i]; a push is visible to the arbiter on the next cycle.
  - ch_valid[i] while full: data dropped, overflow[i] set and held until reset.
- FSM states:
  - INIT: wait for dsm_base_valid and !wr_almostfull, then issue one status write and move to RUN.
  - RUN: normal arbitration.
  - FLUSH: entered on flush from any state; clears FIFOs and offsets; returns to RUN after 1 cycle, or to INIT if dsm_base_valid=0.
- Arbitration in RUN, once per cycle, only when !wr_almostfull:
  - Status first: status_req selects a status write.
  - Otherwise round-robin over channels whose FIFO is non-empty and whose ch_lines is non-zero, starting at the pointer.
  - After a channel is granted, the pointer moves to granted+1 mod NUM_CH.
  - At most one write per cycle.
- Output is registered, 1-cycle latency from grant.
  - Status write: wr_valid=1, wr_phys=1, wr_addr=dsm_base, wr_data=status_data. status_ack pulses in the same cycle as wr_valid.
  - Channel i write: wr_valid=1, wr_phys=0, wr_addr=ch_base[i]+off[i] (mod 2^ADDR_W), wr_data=FIFO head; the FIFO pops on grant.
- wr_almostfull high: no grant that cycle; wr_valid=0 on the next cycle. A request already registered still issues.
- Offset wrap:
  - off[i] increments on each grant of channel i.
  - When off[i] == ch_lines[i]-1 on grant, off[i] becomes 0 and ch_done[i] pulses with that write's wr_valid.
- tx_count increments on every wr_valid and wraps at 2^32.
- Simultaneous events:
  - status_req with a non-empty FIFO: status wins; the FIFO waits.
  - Push and pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged, and this is legal when full.
  - flush has priority over grant and push in the same cycle.
- Reset asserted mid-operation clears everything immediately; no write is issued from state captured before reset.

Test Plan:
- Reset, dsm_base=0x100, dsm_base_valid=1 -> exactly one write with wr_phys=1, wr_addr=0x100; status_ack pulses; tx_count=1.
- NUM_CH=2, ch_lines={4,4}, ch_base={0x1000,0x2000}, 4 lines pushed to each channel back-to-back -> writes alternate 0x1000, 0x2000, 0x1001, 0x2001 … 0x1003, 0x2003; each channel's ch_done pulses once, on its 0x...3 write.
- status_req held 1 cycle while both FIFOs are non-empty -> the status write goes first; channel order resumes from the saved pointer.
- wr_almostfull=1 for 10 cycles with the FIFOs full -> at most 1 wr_valid after assertion, ch_ready=0, no data loss; issue resumes 1 cycle after deassert.
- Push FIFO_DEPTH+1 lines with almostfull=1 -> overflow[0]=1 stays set; the first 32 lines are later written intact.
- flush after 2 of 4 lines on ch0 -> FIFOs empty; the next ch0 write goes to 0x1000.
